// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, asynchronous imem address, IF/ID pipeline register
// and a retired-fetch counter. Handles stall, flush and PC redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] ir_q, ir_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        load;

  // Redirect targets are word-aligned; the dropped low bits are intentionally ignored.
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[1:0];

  assign pc_plus4 = pc_q + 32'd4;
  assign load     = !flush && !stall;

  // Next PC: redirect wins over stall, so a taken branch is never lost behind a hazard.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  // IF/ID next state: flush keeps id_pc/id_pc4 so the bubble still carries a sane address.
  always_comb begin
    ir_d     = ir_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    if (flush) begin
      ir_d    = NOP_WORD;
      valid_d = 1'b0;
    end else if (load) begin
      ir_d     = imem_dout;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      valid_d  = 1'b1;
      cnt_d    = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q     <= NOP_WORD;
      id_pc_q  <= 32'd0;
      id_pc4_q <= 32'd0;
      valid_q  <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      ir_q     <= ir_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_ir     = ir_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = valid_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized control checked against an
// abstract fetch model that tracks the architectural PC, IF/ID slot and fetch count.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] id_ir;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [64];

  // Model state: what the stage should hold after each edge.
  logic [31:0] m_pc, m_ir, m_id_pc, m_id_pc4, m_cnt;
  logic        m_valid;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_WORD(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_dout  (imem_dout),
    .stall      (stall),
    .flush      (flush),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ir      (id_ir),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tb_word(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return a ^ 32'h5A5A_3C3C ^ {a[15:0], a[31:16]};
  endfunction

  assign imem_dout = tb_word(imem_addr);

  task automatic model_edge(input logic r, input logic s, input logic f, input logic rd,
                            input logic [31:0] rpc);
    logic [31:0] old_pc;
    if (r) begin
      m_pc = 32'h0; m_ir = NOP; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0; m_cnt = 0;
    end else begin
      old_pc = m_pc;
      if (f) begin
        m_ir = NOP;
        m_valid = 0;
      end else if (!s) begin
        m_ir = tb_word(old_pc);
        m_id_pc = old_pc;
        m_id_pc4 = old_pc + 32'd4;
        m_valid = 1;
        m_cnt = m_cnt + 32'd1;
      end
      if (rd) m_pc = (rpc / 4) * 4;
      else if (!s) m_pc = old_pc + 32'd4;
    end
  endtask

  // Drive one cycle of control, advance the model on the edge, return at the falling edge.
  task automatic tick(input logic r, input logic s, input logic f, input logic rd,
                      input logic [31:0] rpc);
    rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    model_edge(r, s, f, rd, rpc);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h0) begin
      n_errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0);
    end
    n_checks++;
    if (id_valid !== 1'b0 || id_ir !== NOP) begin
      n_errors++; $display("FAIL reset_ifid: got valid=%b ir=%h want valid=0 ir=%h",
                           id_valid, id_ir, NOP);
    end
    n_checks++;
    if (id_pc !== 32'h0 || id_pc4 !== 32'h0 || fetch_cnt !== 32'h0) begin
      n_errors++; $display("FAIL reset_pcs: got id_pc=%h id_pc4=%h cnt=%0d want 0/0/0",
                           id_pc, id_pc4, fetch_cnt);
    end
  endtask

  task automatic test_sequential();
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h4 || id_ir !== 32'h2008_0001 || id_valid !== 1'b1) begin
      n_errors++; $display("FAIL seq_first: got addr=%h ir=%h valid=%b want 4/20080001/1",
                           imem_addr, id_ir, id_valid);
    end
    n_checks++;
    if (id_pc !== 32'h0 || id_pc4 !== 32'h4 || fetch_cnt !== 32'd1) begin
      n_errors++; $display("FAIL seq_first_pc: got id_pc=%h id_pc4=%h cnt=%0d want 0/4/1",
                           id_pc, id_pc4, fetch_cnt);
    end
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h8 || id_ir !== 32'h2009_0002 || fetch_cnt !== 32'd2) begin
      n_errors++; $display("FAIL seq_second: got addr=%h ir=%h cnt=%0d want 8/20090002/2",
                           imem_addr, id_ir, fetch_cnt);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 0, 0, 32'h0);
      n_checks++;
      if (imem_addr !== 32'h8 || id_ir !== 32'h2009_0002 || fetch_cnt !== 32'd2) begin
        n_errors++; $display("FAIL stall_hold%0d: got addr=%h ir=%h cnt=%0d want 8/20090002/2",
                             i, imem_addr, id_ir, fetch_cnt);
      end
    end
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'hC || id_ir !== 32'h200A_0003 || id_pc !== 32'h8
        || fetch_cnt !== 32'd3) begin
      n_errors++; $display("FAIL stall_resume: got addr=%h ir=%h id_pc=%h cnt=%0d want C/200A0003/8/3",
                           imem_addr, id_ir, id_pc, fetch_cnt);
    end
  endtask

  task automatic test_taken_branch();
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h10 || fetch_cnt !== 32'd4) begin
      n_errors++; $display("FAIL br_setup: got addr=%h cnt=%0d want 10/4", imem_addr, fetch_cnt);
    end
    tick(0, 0, 1, 1, 32'h40);
    n_checks++;
    if (imem_addr !== 32'h40 || id_valid !== 1'b0 || id_ir !== 32'h0) begin
      n_errors++; $display("FAIL br_bubble: got addr=%h valid=%b ir=%h want 40/0/0",
                           imem_addr, id_valid, id_ir);
    end
    n_checks++;
    if (fetch_cnt !== 32'd4 || id_pc !== 32'hC || id_pc4 !== 32'h10) begin
      n_errors++; $display("FAIL br_hold: got cnt=%0d id_pc=%h id_pc4=%h want 4/C/10",
                           fetch_cnt, id_pc, id_pc4);
    end
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (id_ir !== tb_word(32'h40) || id_pc !== 32'h40 || id_pc4 !== 32'h44
        || id_valid !== 1'b1 || fetch_cnt !== 32'd5) begin
      n_errors++; $display("FAIL br_target: got ir=%h id_pc=%h id_pc4=%h valid=%b cnt=%0d want %h/40/44/1/5",
                           id_ir, id_pc, id_pc4, id_valid, fetch_cnt, tb_word(32'h40));
    end
  endtask

  task automatic test_redirect_stall();
    tick(0, 1, 0, 1, 32'h83);
    n_checks++;
    if (imem_addr !== 32'h80) begin
      n_errors++; $display("FAIL rdst_pc: got %h want %h", imem_addr, 32'h80);
    end
    n_checks++;
    if (id_ir !== tb_word(32'h40) || id_pc !== 32'h40 || id_pc4 !== 32'h44
        || fetch_cnt !== 32'd5) begin
      n_errors++; $display("FAIL rdst_hold: got ir=%h id_pc=%h id_pc4=%h cnt=%0d want %h/40/44/5",
                           id_ir, id_pc, id_pc4, fetch_cnt, tb_word(32'h40));
    end
  endtask

  task automatic test_comb_path();
    // Control inputs must not reach imem_addr between edges.
    redirect = 1; redirect_pc = 32'h200; stall = 1; flush = 1;
    #2;
    n_checks++;
    if (imem_addr !== 32'h80) begin
      n_errors++; $display("FAIL comb_path: got %h want %h", imem_addr, 32'h80);
    end
    redirect = 0; redirect_pc = 0; stall = 0; flush = 0;
  endtask

  task automatic test_reset_midrun();
    tick(0, 0, 0, 1, 32'h24);
    n_checks++;
    if (imem_addr !== 32'h24 || id_pc !== 32'h80 || fetch_cnt !== 32'd6) begin
      n_errors++; $display("FAIL mid_setup: got addr=%h id_pc=%h cnt=%0d want 24/80/6",
                           imem_addr, id_pc, fetch_cnt);
    end
    tick(1, 1, 0, 1, 32'h100);
    n_checks++;
    if (imem_addr !== 32'h0 || id_valid !== 1'b0 || fetch_cnt !== 32'd0
        || id_pc !== 32'h0 || id_ir !== NOP) begin
      n_errors++; $display("FAIL mid_reset: got addr=%h valid=%b cnt=%0d id_pc=%h ir=%h want 0/0/0/0/0",
                           imem_addr, id_valid, fetch_cnt, id_pc, id_ir);
    end
  endtask

  task automatic test_wrap();
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (id_ir !== 32'h2008_0001 || fetch_cnt !== 32'd1) begin
      n_errors++; $display("FAIL wrap_restart: got ir=%h cnt=%0d want 20080001/1", id_ir, fetch_cnt);
    end
    tick(0, 0, 0, 1, 32'hFFFF_FFFC);
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_force: got %h want FFFFFFFC", imem_addr);
    end
    tick(0, 0, 0, 0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0
        || id_ir !== tb_word(32'hFFFF_FFFC)) begin
      n_errors++; $display("FAIL wrap_next: got addr=%h id_pc=%h id_pc4=%h ir=%h want 0/FFFFFFFC/0/%h",
                           imem_addr, id_pc, id_pc4, id_ir, tb_word(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_random();
    logic        r, s, f, rd;
    logic [31:0] rpc;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) < 3);
      s   = ($urandom_range(0, 99) < 25);
      f   = ($urandom_range(0, 99) < 20);
      rd  = ($urandom_range(0, 99) < 20);
      rpc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom;
      tick(r, s, f, rd, rpc);
      n_checks++;
      if (imem_addr !== m_pc) begin
        n_errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, imem_addr, m_pc);
      end
      n_checks++;
      if (id_ir !== m_ir || id_valid !== m_valid) begin
        n_errors++; $display("FAIL rnd_ir[%0d]: got ir=%h valid=%b want ir=%h valid=%b",
                             i, id_ir, id_valid, m_ir, m_valid);
      end
      n_checks++;
      if (id_pc !== m_id_pc || id_pc4 !== m_id_pc4) begin
        n_errors++; $display("FAIL rnd_idpc[%0d]: got %h/%h want %h/%h",
                             i, id_pc, id_pc4, m_id_pc, m_id_pc4);
      end
      n_checks++;
      if (fetch_cnt !== m_cnt) begin
        n_errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, fetch_cnt, m_cnt);
      end
    end
  endtask

  initial begin
    clk = 0; rst = 1; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h200A_0003;
    m_pc = 0; m_ir = NOP; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_taken_branch();
    test_redirect_stall();
    test_comb_path();
    test_reset_midrun();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
